tone_decoder: RTL and testbench
===============================

Name: tone_decoder

Overview:
- Receiving end of the square-wave audio line driven by the background-music generator.
- Samples a single-bit tone input, measures the full period between rising edges and classifies it against the eight note periods the generator produces: F3 G3 A3 B3 C4 D4 E4 G4.
- Reports a stable note code, a silence flag and a note-change pulse.
- Used for loopback self-test of the music path and to drive the on-screen note indicator.
- System clock is 100 MHz.

Parameters:
- CNT_W, 20, period counter / period output width.
- TOL, 4096, max |measured - nominal| in clk cycles for a note match.
- MATCH_COUNT, 2, consecutive identical classifications required before note_code updates (range 1..7).
- SILENCE_CYC, 600000, cycles without a rising edge before silence is declared; must be less than 2^CNT_W - 1.

Ports:
- clk, input, 1, system clock, 100 MHz.
- reset, input, 1, asynchronous active-high reset.
- tone_in, input, 1, asynchronous square-wave tone (speaker line).
- note_code, output, 4, 0 = silence, 1..8 = F3 G3 A3 B3 C4 D4 E4 G4, 9 = unknown tone.
- note_valid, output, 1, high while note_code is in 1..8.
- note_change, output, 1, one-cycle pulse whenever note_code changes value.
- silence, output, 1, high while no tone is detected (note_code == 0).
- period, output, CNT_W, last measured full period in clk cycles.

Behaviour:
- **Clock and reset.** One clock domain: clk. Reset is asynchronous, active-high, on port reset. All flops clear on reset.
- **Reset values.** note_code = 0, note_valid = 0, note_change = 0, silence = 1, period = 0, state = IDLE, match counter = 0, candidate = 0, period counter = 0. Asserting reset mid-measurement discards all partial state.
- **Input sync.** tone_in passes through a 2-flop synchronizer plus one edge flop. rise = s2 & ~s3. Only rising edges are used.
- **Period counter.** Increments every cycle in MEASURE and saturates at 2^CNT_W - 1. On rise it loads 1.
- **FSM, IDLE.** Silence state. On rise: go to MEASURE, counter = 1. No period is produced.
- **FSM, MEASURE.**
  - On rise: period <= counter value, counter <= 1, classify strobe is raised for the next cycle.
  - If counter reaches SILENCE_CYC with no rise: go to IDLE. Clear the match counter and candidate. note_code <= 0. Pulse note_change if the old note_code was nonzero.
  - If rise and timeout occur in the same cycle, the timeout is processed first and the rise is treated as the first edge from IDLE: state MEASURE, counter = 1, no period.
- **Classification (cycle after period load).** Nominal full periods in cycles: F3 572704, G3 510204, A3 454546, B3 404956, C4 382220, D4 340518, E4 303370, G4 255102.
  - cls = first code whose |period - nominal| <= TOL, otherwise 9.
  - Use unsigned compare with explicit ordering; no signed wrap.
- **Confirmation.**
  - If cls == candidate, the match counter increments, saturating at MATCH_COUNT.
  - Otherwise candidate <= cls and the match counter <= 1.
  - When the match counter equals MATCH_COUNT and candidate != note_code: note_code <= candidate and note_change pulses for 1 cycle.
  - note_valid and silence are derived registered from note_code and update in the same cycle as note_code.
- **Latency.** note_code updates 2 clk after the rise pulse of the confirming edge, i.e. 5 clk after the tone_in edge reaches the first sync flop.
- **Glitches.** A very short period (glitch edge) classifies as 9 and resets confirmation. It cannot change note_code unless it repeats MATCH_COUNT times.
- **Held note.** A note held across many periods gives no further note_change.
- **Repeated note across a gap.** A note followed by a silence gap and then the same note produces note_change to 0 and then note_change back to the note.

Test Plan:
- **Reset values.** Assert reset mid-tone → all outputs at reset values within the same cycle. Release reset, hold tone_in = 0 → silence stays 1 and note_code stays 0 indefinitely.
- **A3 detection.** Square wave, period 454546 cycles, 3 periods → period = 454546. note_code = 3 and note_valid = 1 after the 3rd rising edge (MATCH_COUNT = 2; the 1st edge gives no period). Exactly one note_change pulse.
- **Note change C4 to D4.** C4 (382220) then D4 (340518) → note_code 5, then 6 after 2 D4 periods. One note_change at each transition.
- **Tolerance edges.** Period 382220 + 4096 → code 5. Period 382220 + 4097 → code 9 with note_valid = 0 after 2 periods.
- **Silence timeout.** G4 tone stops with tone_in held at 1 → exactly SILENCE_CYC cycles after the last rise: note_code = 0, silence = 1, one note_change pulse. The next rise produces no period update.
- **Glitch rejection.** E4 tone with a single extra edge 1000 cycles after a rise → note_code stays 7 and no note_change pulse.

Source files
------------

// File: rtl/tone_decoder.sv
// Tone decoder: measures the period between rising edges of a square-wave tone and classifies
// it against the eight note periods of the background-music generator.
module tone_decoder #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned TOL         = 4096,
    parameter int unsigned MATCH_COUNT = 2,
    parameter int unsigned SILENCE_CYC = 600000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tone_in,
    output logic [3:0]       note_code,
    output logic             note_valid,
    output logic             note_change,
    output logic             silence,
    output logic [CNT_W-1:0] period
);

    typedef enum logic [0:0] {StIdle, StMeasure} state_e;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SilenceCnt = CNT_W'(SILENCE_CYC);
    localparam logic [2:0]       MatchMax   = 3'(MATCH_COUNT);

    function automatic int unsigned nominal(input int unsigned idx);
        case (idx)
            0:       return 572704;
            1:       return 510204;
            2:       return 454546;
            3:       return 404956;
            4:       return 382220;
            5:       return 340518;
            6:       return 303370;
            default: return 255102;
        endcase
    endfunction

    // Ordered unsigned distance; never subtracts the larger value from the smaller.
    function automatic logic near(input logic [CNT_W-1:0] p, input int unsigned nom);
        int unsigned pe;
        pe = 32'(p);
        if (pe >= nom) return (pe - nom) <= TOL;
        return (nom - pe) <= TOL;
    endfunction

    // Scan downwards so the lowest matching code wins.
    function automatic logic [3:0] classify(input logic [CNT_W-1:0] p);
        logic [3:0] code;
        code = 4'd9;
        for (int unsigned i = 8; i > 0; i--) begin
            if (near(p, nominal(i - 1))) code = 4'(i);
        end
        return code;
    endfunction

    logic             s1_q, s2_q, s3_q;
    logic             rise;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       cand_q, cand_d;
    logic [2:0]       match_q, match_d;
    logic [3:0]       code_q, code_d;
    logic             valid_q, silence_q, change_q;
    logic [3:0]       cls;
    logic             timeout;

    assign rise = s2_q & ~s3_q;
    assign cls  = classify(period_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        strobe_d = 1'b0;
        cand_d   = cand_q;
        match_d  = match_q;
        code_d   = code_q;
        timeout  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                    cnt_d   = CntOne;
                end
            end
            StMeasure: begin
                if (cnt_q == SilenceCnt) begin
                    // A coincident rise restarts measurement as if seen from idle.
                    timeout = 1'b1;
                    state_d = rise ? StMeasure : StIdle;
                    cnt_d   = rise ? CntOne : '0;
                end else if (rise) begin
                    period_d = cnt_q;
                    cnt_d    = CntOne;
                    strobe_d = 1'b1;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: state_d = StIdle;
        endcase

        if (timeout) begin
            cand_d  = '0;
            match_d = '0;
            code_d  = '0;
        end else begin
            if (strobe_q) begin
                if (cls == cand_q) begin
                    if (match_q != MatchMax) match_d = match_q + 3'd1;
                end else begin
                    cand_d  = cls;
                    match_d = 3'd1;
                end
            end
            if (match_q == MatchMax && cand_q != code_q) code_d = cand_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= StIdle;
            cnt_q     <= '0;
            period_q  <= '0;
            strobe_q  <= 1'b0;
            cand_q    <= '0;
            match_q   <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            silence_q <= 1'b1;
            change_q  <= 1'b0;
        end else begin
            s1_q      <= tone_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            strobe_q  <= strobe_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            code_q    <= code_d;
            valid_q   <= (code_d != 4'd0) && (code_d <= 4'd8);
            silence_q <= (code_d == 4'd0);
            change_q  <= (code_d != code_q);
        end
    end

    assign note_code   = code_q;
    assign note_valid  = valid_q;
    assign note_change = change_q;
    assign silence     = silence_q;
    assign period      = period_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: note detection, tolerance edges, glitch and silence handling.
module tb_tone_decoder;

    localparam int unsigned A3 = 454546;
    localparam int unsigned C4 = 382220;
    localparam int unsigned D4 = 340518;
    localparam int unsigned E4 = 303370;
    localparam int unsigned G4 = 255102;

    logic        clk = 1'b0;
    logic        reset;
    logic        tone_in;
    logic [3:0]  note_code;
    logic        note_valid;
    logic        note_change;
    logic        silence;
    logic [19:0] period;

    int n_cmp = 0;
    int n_err = 0;
    int n_chg = 0;
    int base;

    tone_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .tone_in    (tone_in),
        .note_code  (note_code),
        .note_valid (note_valid),
        .note_change(note_change),
        .silence    (silence),
        .period     (period)
    );

    always #5 clk = ~clk;

    // note_change is a one-cycle registered pulse, so each pulse is seen at exactly one negedge.
    always @(negedge clk) if (note_change) n_chg <= n_chg + 1;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every wait ends 1 time unit after a rising clock edge.
    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int unsigned p);
        tone_in = 1'b1;
        wait_cyc(p / 2);
        tone_in = 1'b0;
        wait_cyc(p - p / 2);
    endtask

    initial begin
        reset   = 1'b1;
        tone_in = 1'b0;
        wait_cyc(3);
        check("rst_code", 32'(note_code), 0);
        check("rst_valid", 32'(note_valid), 0);
        check("rst_change", 32'(note_change), 0);
        check("rst_silence", 32'(silence), 1);
        check("rst_period", 32'(period), 0);
        reset = 1'b0;
        wait_cyc(5);

        // Short tone confirms as unknown, then reset lands mid-measurement.
        pulse(1000);
        pulse(1000);
        tone_in = 1'b1;
        wait_cyc(10);
        check("pre_rst_period", 32'(period), 1000);
        check("pre_rst_code", 32'(note_code), 9);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_code", 32'(note_code), 0);
        check("mid_rst_silence", 32'(silence), 1);
        check("mid_rst_period", 32'(period), 0);
        check("mid_rst_change", 32'(note_change), 0);
        wait_cyc(2);
        tone_in = 1'b0;
        reset   = 1'b0;
        wait_cyc(2000);
        check("idle_silence", 32'(silence), 1);
        check("idle_code", 32'(note_code), 0);

        // A3: confirmed 5 cycles after the third rise is driven.
        base = n_chg;
        pulse(A3);
        pulse(A3);
        tone_in = 1'b1;
        wait_cyc(4);
        check("a3_lat_before", 32'(note_code), 0);
        wait_cyc(1);
        check("a3_code", 32'(note_code), 3);
        check("a3_change_pulse", 32'(note_change), 1);
        check("a3_valid", 32'(note_valid), 1);
        check("a3_silence", 32'(silence), 0);
        wait_cyc(1);
        check("a3_change_end", 32'(note_change), 0);
        wait_cyc(A3 / 2 - 6);
        tone_in = 1'b0;
        wait_cyc(A3 - A3 / 2);
        check("a3_period", 32'(period), A3);
        check("a3_nchg", 32'(n_chg - base), 1);

        // C4 then D4.
        base = n_chg;
        repeat (3) pulse(C4);
        check("c4_code", 32'(note_code), 5);
        check("c4_period", 32'(period), C4);
        check("c4_nchg", 32'(n_chg - base), 1);
        base = n_chg;
        repeat (3) pulse(D4);
        check("d4_code", 32'(note_code), 6);
        check("d4_nchg", 32'(n_chg - base), 1);

        // Tolerance edges around C4.
        base = n_chg;
        repeat (3) pulse(C4 + 4096);
        check("tol_in_code", 32'(note_code), 5);
        check("tol_in_period", 32'(period), C4 + 4096);
        check("tol_in_nchg", 32'(n_chg - base), 1);
        base = n_chg;
        repeat (3) pulse(C4 + 4097);
        check("tol_out_code", 32'(note_code), 9);
        check("tol_out_valid", 32'(note_valid), 0);
        check("tol_out_silence", 32'(silence), 0);
        check("tol_out_nchg", 32'(n_chg - base), 1);

        // E4 with one glitch edge 1000 cycles after a rise.
        repeat (3) pulse(E4);
        check("e4_code", 32'(note_code), 7);
        base = n_chg;
        tone_in = 1'b1;
        wait_cyc(10);
        tone_in = 1'b0;
        wait_cyc(990);
        tone_in = 1'b1;
        wait_cyc(10);
        check("glitch_period", 32'(period), 1000);
        wait_cyc(E4 / 2 - 1010);
        tone_in = 1'b0;
        wait_cyc(E4 - E4 / 2);
        pulse(E4);
        pulse(E4);
        check("glitch_code", 32'(note_code), 7);
        check("glitch_period_after", 32'(period), E4);
        check("glitch_nchg", 32'(n_chg - base), 0);

        // G4, then tone held high until the silence timeout.
        repeat (3) pulse(G4);
        check("g4_code", 32'(note_code), 8);
        tone_in = 1'b1;
        wait_cyc(10);
        check("g4_period", 32'(period), G4);
        base = n_chg;
        wait_cyc(600002 - 10);
        check("sil_before", 32'(note_code), 8);
        wait_cyc(1);
        check("sil_code", 32'(note_code), 0);
        check("sil_silence", 32'(silence), 1);
        check("sil_valid", 32'(note_valid), 0);
        check("sil_change", 32'(note_change), 1);
        wait_cyc(1);
        check("sil_change_end", 32'(note_change), 0);
        check("sil_nchg", 32'(n_chg - base), 1);
        tone_in = 1'b0;
        wait_cyc(100);
        tone_in = 1'b1;
        wait_cyc(10);
        check("sil_first_rise_period", 32'(period), G4);
        check("sil_first_rise_code", 32'(note_code), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
